// File: rtl/l2_coh_pkg.sv
// Shared types for the L2 MESI coherence controller: line states, command
// encodings, snoop results, bus operations and the sequencer state enum.
package l2_coh_pkg;

    typedef enum logic [1:0] {
        MESI_M = 2'b00,
        MESI_E = 2'b01,
        MESI_S = 2'b10,
        MESI_I = 2'b11
    } mesi_t;

    // L1 and snoop command codes share one space; they never overlap.
    typedef enum logic [3:0] {
        CMD_RD   = 4'd0,
        CMD_WR   = 4'd1,
        CMD_IRD  = 4'd2,
        CMD_SINV = 4'd3,
        CMD_SRD  = 4'd4,
        CMD_SWR  = 4'd5,
        CMD_SRFO = 4'd6,
        CMD_CLR  = 4'd8,
        CMD_PRT  = 4'd9
    } cmd_t;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10
    } snp_resp_t;

    typedef enum logic [1:0] {
        BUS_READ = 2'b00,
        BUS_RFO  = 2'b01,
        BUS_WB   = 2'b10,
        BUS_INV  = 2'b11
    } bus_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WB      = 3'd2,
        ST_BUSOP   = 3'd3,
        ST_SNPRESP = 3'd4,
        ST_UPDATE  = 3'd5
    } fsm_t;

    function automatic logic is_l1_cmd(input logic [3:0] c);
        return (c == CMD_RD) || (c == CMD_WR) || (c == CMD_IRD) ||
               (c == CMD_CLR) || (c == CMD_PRT);
    endfunction

    function automatic logic is_snp_cmd(input logic [3:0] c);
        return (c == CMD_SINV) || (c == CMD_SRD) || (c == CMD_SWR) || (c == CMD_SRFO);
    endfunction

endpackage

// File: rtl/l2_mesi_next.sv
// Pure combinational MESI transition table. i_state is the effective line
// state (already forced to I on a tag miss). Produces the next line state,
// the snoop result code and whether a snoop must write the line back first.
module l2_mesi_next
    import l2_coh_pkg::*;
(
    input  logic [1:0] i_state,
    input  logic [3:0] i_cmd,
    input  logic [1:0] i_bus_resp,
    output logic [1:0] o_next_state,
    output logic [1:0] o_snp_result,
    output logic       o_snp_wb
);

    // Transition table; anything not listed (clear, print, unknown) ends in I.
    always_comb begin
        o_next_state = MESI_I;
        o_snp_result = SNP_NOHIT;
        o_snp_wb     = 1'b0;
        case (i_cmd)
            CMD_RD, CMD_IRD: begin
                if (i_state != MESI_I)
                    o_next_state = i_state;
                else
                    o_next_state = (i_bus_resp == SNP_NOHIT) ? MESI_E : MESI_S;
            end
            CMD_WR: o_next_state = MESI_M;
            CMD_SRD: begin
                if (i_state == MESI_M) begin
                    o_next_state = MESI_S;
                    o_snp_result = SNP_HITM;
                    o_snp_wb     = 1'b1;
                end else if (i_state != MESI_I) begin
                    o_next_state = MESI_S;
                    o_snp_result = SNP_HIT;
                end
            end
            CMD_SRFO: begin
                if (i_state == MESI_M) begin
                    o_snp_result = SNP_HITM;
                    o_snp_wb     = 1'b1;
                end else if (i_state != MESI_I) begin
                    o_snp_result = SNP_HIT;
                end
            end
            CMD_SINV: begin
                if (i_state != MESI_I)
                    o_snp_result = SNP_HIT;
            end
            CMD_SWR: o_next_state = i_state;
            default: o_next_state = MESI_I;
        endcase
    end

endmodule

// File: rtl/l2_coherence_ctrl.sv
// L2 MESI coherence sequencer: arbitrates the L1 and snoop ports (snoop
// wins), looks up a direct-mapped tag/state array, issues bus operations,
// drives snoop results and retires L1 commands with a done pulse.
// Optional build macro L2_COH_STATS_EN adds saturating hit/miss/writeback counters.
module l2_coherence_ctrl
    import l2_coh_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 6,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l1_valid,
    output logic              l1_ready,
    input  logic [3:0]        l1_cmd,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic              snp_valid,
    output logic              snp_ready,
    input  logic [3:0]        snp_cmd,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              snp_result_valid,
    output logic [1:0]        snp_result,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [1:0]        bus_snoop_resp,
    output logic              done_valid,
    output logic [1:0]        done_state,
    output logic              busy
`ifdef L2_COH_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_wbs
`endif
);

    localparam int LINES = 1 << INDEX_W;

    fsm_t               r_fsm;
    logic               r_is_snp;
    logic [3:0]         r_cmd;
    logic [INDEX_W-1:0] r_index;
    logic [TAG_W-1:0]   r_tag;
    logic [1:0]         r_eff;
    logic [1:0]         r_new_state;
    logic [1:0]         r_snp_code;
    logic               r_bus_valid;
    logic [1:0]         r_bus_op;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic               r_done_valid;
    logic [1:0]         r_done_state;
    logic               r_snp_valid;
    logic [1:0]         r_snp_result;

    logic [1:0]         w_state_arr [LINES];
    logic [TAG_W-1:0]   w_tag_arr   [LINES];
    logic [1:0]         w_cur_state;
    logic [TAG_W-1:0]   w_cur_tag;
    logic               w_hit;
    logic [1:0]         w_eff;
    logic [1:0]         w_mn_state;
    logic [1:0]         w_mn_next;
    logic [1:0]         w_mn_snp;
    logic               w_mn_wb;
    logic               w_is_fill;
    logic               w_need_bus;
    logic [1:0]         w_fill_op;
    logic               w_clear_all;
    logic               w_line_we;
    logic [ADDR_W-1:0]  w_line_addr;
    logic [ADDR_W-1:0]  w_victim_addr;
    logic               w_unused;

    assign l1_ready  = (r_fsm == ST_IDLE) && l1_valid && !snp_valid;
    assign snp_ready = (r_fsm == ST_IDLE) && snp_valid;
    assign busy      = (r_fsm != ST_IDLE);

    assign bus_valid        = r_bus_valid;
    assign bus_op           = r_bus_op;
    assign bus_addr         = r_bus_addr;
    assign done_valid       = r_done_valid;
    assign done_state       = r_done_state;
    assign snp_result_valid = r_snp_valid;
    assign snp_result       = r_snp_result;

    // Byte offsets never matter: every bus address is line aligned.
    assign w_unused = ^{l1_addr[OFFSET_W-1:0], snp_addr[OFFSET_W-1:0]};

    assign w_cur_state   = w_state_arr[r_index];
    assign w_cur_tag     = w_tag_arr[r_index];
    assign w_hit         = (w_cur_state != MESI_I) && (w_cur_tag == r_tag);
    assign w_eff         = w_hit ? w_cur_state : MESI_I;
    assign w_line_addr   = {r_tag, r_index, {OFFSET_W{1'b0}}};
    assign w_victim_addr = {w_cur_tag, r_index, {OFFSET_W{1'b0}}};
    assign w_is_fill     = (r_cmd == CMD_RD) || (r_cmd == CMD_IRD) || (r_cmd == CMD_WR);
    assign w_need_bus    = w_is_fill && (!w_hit || (r_cmd == CMD_WR && w_cur_state == MESI_S));
    assign w_fill_op     = (r_cmd == CMD_WR) ? BUS_RFO : BUS_READ;

    // In LOOKUP the array is live; later the captured effective state is used
    // so the READ response can be folded in at the bus handshake.
    assign w_mn_state = (r_fsm == ST_LOOKUP) ? w_eff : r_eff;

    l2_mesi_next u_mesi_next (
        .i_state      (w_mn_state),
        .i_cmd        (r_cmd),
        .i_bus_resp   (bus_snoop_resp),
        .o_next_state (w_mn_next),
        .o_snp_result (w_mn_snp),
        .o_snp_wb     (w_mn_wb)
    );

    // Snoop misses must never touch the line that happens to sit in the set.
    assign w_clear_all = (r_fsm == ST_UPDATE) && !r_is_snp && (r_cmd == CMD_CLR);
    assign w_line_we   = ((r_fsm == ST_UPDATE) && !r_is_snp && w_is_fill) ||
                         ((r_fsm == ST_SNPRESP) && (r_eff != MESI_I));

    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
        logic [1:0]       r_st;
        logic [TAG_W-1:0] r_tg;
        // One line of the state/tag array; clear wipes every line at once.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_st <= MESI_I;
                r_tg <= '0;
            end else if (w_clear_all) begin
                r_st <= MESI_I;
            end else if (w_line_we && (r_index == INDEX_W'(gi))) begin
                r_st <= r_new_state;
                r_tg <= r_tag;
            end
        end
        assign w_state_arr[gi] = r_st;
        assign w_tag_arr[gi]   = r_tg;
    end

    // Sequencer FSM with registered bus, done and snoop-result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= ST_IDLE;
            r_is_snp     <= 1'b0;
            r_cmd        <= '0;
            r_index      <= '0;
            r_tag        <= '0;
            r_eff        <= MESI_I;
            r_new_state  <= MESI_I;
            r_snp_code   <= '0;
            r_bus_valid  <= 1'b0;
            r_bus_op     <= '0;
            r_bus_addr   <= '0;
            r_done_valid <= 1'b0;
            r_done_state <= '0;
            r_snp_valid  <= 1'b0;
            r_snp_result <= '0;
        end else begin
            r_done_valid <= 1'b0;
            r_done_state <= '0;
            r_snp_valid  <= 1'b0;
            r_snp_result <= '0;
            case (r_fsm)
                ST_IDLE: begin
                    if (snp_valid) begin
                        r_is_snp <= is_snp_cmd(snp_cmd);
                        r_cmd    <= is_snp_cmd(snp_cmd) ? snp_cmd : CMD_PRT;
                        r_index  <= snp_addr[OFFSET_W +: INDEX_W];
                        r_tag    <= snp_addr[ADDR_W-1 -: TAG_W];
                        r_fsm    <= ST_LOOKUP;
                    end else if (l1_valid) begin
                        r_is_snp <= 1'b0;
                        r_cmd    <= is_l1_cmd(l1_cmd) ? l1_cmd : CMD_PRT;
                        r_index  <= l1_addr[OFFSET_W +: INDEX_W];
                        r_tag    <= l1_addr[ADDR_W-1 -: TAG_W];
                        r_fsm    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_eff       <= w_eff;
                    r_new_state <= w_mn_next;
                    r_snp_code  <= w_mn_snp;
                    if (r_is_snp) begin
                        if (w_mn_wb) begin
                            r_bus_valid <= 1'b1;
                            r_bus_op    <= BUS_WB;
                            r_bus_addr  <= w_line_addr;
                            r_fsm       <= ST_WB;
                        end else begin
                            r_snp_valid  <= 1'b1;
                            r_snp_result <= w_mn_snp;
                            r_fsm        <= ST_SNPRESP;
                        end
                    end else if (!w_need_bus) begin
                        r_done_valid <= 1'b1;
                        r_done_state <= w_mn_next;
                        r_fsm        <= ST_UPDATE;
                    end else begin
                        r_bus_valid <= 1'b1;
                        if (w_hit) begin
                            r_bus_op   <= BUS_INV;
                            r_bus_addr <= w_line_addr;
                            r_fsm      <= ST_BUSOP;
                        end else if (w_cur_state == MESI_M) begin
                            r_bus_op   <= BUS_WB;
                            r_bus_addr <= w_victim_addr;
                            r_fsm      <= ST_WB;
                        end else begin
                            r_bus_op   <= w_fill_op;
                            r_bus_addr <= w_line_addr;
                            r_fsm      <= ST_BUSOP;
                        end
                    end
                end
                ST_WB: begin
                    if (bus_ready) begin
                        if (r_is_snp) begin
                            r_bus_valid  <= 1'b0;
                            r_snp_valid  <= 1'b1;
                            r_snp_result <= r_snp_code;
                            r_fsm        <= ST_SNPRESP;
                        end else begin
                            r_bus_op   <= w_fill_op;
                            r_bus_addr <= w_line_addr;
                            r_fsm      <= ST_BUSOP;
                        end
                    end
                end
                ST_BUSOP: begin
                    if (bus_ready) begin
                        r_bus_valid  <= 1'b0;
                        r_new_state  <= w_mn_next;
                        r_done_valid <= 1'b1;
                        r_done_state <= w_mn_next;
                        r_fsm        <= ST_UPDATE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

`ifdef L2_COH_STATS_EN
    logic        w_stat_lookup;
    logic        w_stat_wb;
    logic [31:0] r_hits;
    logic [31:0] r_misses;
    logic [31:0] r_wbs;

    assign w_stat_lookup = (r_fsm == ST_LOOKUP) && !r_is_snp && w_is_fill;
    assign w_stat_wb     = (r_fsm == ST_WB) && bus_ready;

    // Saturating event counters; clear leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hits   <= '0;
            r_misses <= '0;
            r_wbs    <= '0;
        end else begin
            if (w_stat_lookup && w_hit && (r_hits != '1))
                r_hits <= r_hits + 32'd1;
            if (w_stat_lookup && !w_hit && (r_misses != '1))
                r_misses <= r_misses + 32'd1;
            if (w_stat_wb && (r_wbs != '1))
                r_wbs <= r_wbs + 32'd1;
        end
    end

    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;
    assign stat_wbs    = r_wbs;
`endif

endmodule

// File: doc/l2_coherence_ctrl.md
Name: l2_coherence_ctrl

Overview:
- Sequencing controller for the L2 MESI line-state array.
- Arbitrates between an L1 request port and a bus snoop port, and looks up a direct-mapped tag/state array.
- Applies MESI transitions, issues bus operations (READ, RFO, WRITEBACK, INVALIDATE) and drives snoop results (NOHIT/HIT/HITM).
- Sits between the L1 interface and the system bus model.

Parameters:
- ADDR_W, 32, address width.
- INDEX_W, 4, set index bits (2**INDEX_W lines).
- OFFSET_W, 6, byte offset bits (64 B lines).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W, stored tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- l1_valid  in  1  L1 command valid.
- l1_ready  out  1  L1 command accepted this cycle.
- l1_cmd  in  4  0 read, 1 write, 2 inst read, 8 clear, 9 print.
- l1_addr  in  ADDR_W  L1 address.
- snp_valid  in  1  snoop valid.
- snp_ready  out  1  snoop accepted this cycle.
- snp_cmd  in  4  3 invalidate, 4 read, 5 write, 6 RFO.
- snp_addr  in  ADDR_W  snooped address.
- snp_result_valid  out  1  one-cycle pulse.
- snp_result  out  2  00 NOHIT, 01 HIT, 10 HITM.
- bus_valid  out  1  bus op request.
- bus_ready  in  1  bus op grant/complete.
- bus_op  out  2  00 READ, 01 RFO, 10 WRITEBACK, 11 INVALIDATE.
- bus_addr  out  ADDR_W  line-aligned address, offset bits zero.
- bus_snoop_resp  in  2  other caches' response, sampled at READ handshake.
- done_valid  out  1  one-cycle pulse, command retired.
- done_state  out  2  final line state: M=00, E=01, S=10, I=11.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset:
  - All outputs 0; FSM IDLE.
  - Every line state I, tags 0.
  - Reset mid-operation aborts the command with no done/result pulse.
- FSM states: IDLE, LOOKUP, WB, BUSOP, SNPRESP, UPDATE.
- Acceptance:
  - l1_ready and snp_ready are high only in IDLE, and only one of them per cycle.
  - Fixed priority: the snoop wins when both ports are valid.
  - Command, address, index and tag are captured at the handshake (cycle 0).
- LOOKUP (cycle 1): hit = state!=I and tag match.
- L1 read / inst read:
  - Hit: state unchanged; done_valid in cycle 2.
  - Miss, victim M: WB with victim address, then READ.
  - Miss, victim not M: READ directly.
  - After READ: bus_snoop_resp HIT or HITM → S; NOHIT → E. New tag is written.
- L1 write:
  - Hit M or E → M, no bus op, done in cycle 2.
  - Hit S → INVALIDATE, then M.
  - Miss → WB if victim M, then RFO, then M.
- Bus handshake:
  - bus_valid and bus_op/bus_addr are held stable until bus_ready.
  - The FSM advances the cycle after the handshake.
  - done_valid follows one cycle after the final handshake (UPDATE).
- Snoops (hit/miss against the captured tag):
  - read: M → HITM, WRITEBACK, then S; E → HIT, then S; S → HIT, stays S; miss → NOHIT.
  - RFO: M → HITM, WRITEBACK, then I; E/S → HIT, then I; miss → NOHIT.
  - invalidate: hit → HIT, then I; miss → NOHIT.
  - write: always NOHIT, state unchanged.
  - snp_result_valid pulses in SNPRESP: cycle 2, or the cycle after the WRITEBACK handshake.
  - done_valid is not pulsed for snoops.
- clear: all lines → I in one cycle; done_valid in cycle 2 with done_state=I.
- print: no state change; done_valid in cycle 2 with done_state=I.
- Undefined l1_cmd/snp_cmd: retired like print.
- done_state is valid only while done_valid=1 and reads 0 otherwise.

Optional Feature:
- Macro L2_COH_STATS_EN.
- Enabled:
  - Adds outputs stat_hits, stat_misses, stat_wbs (32 b each), counting L1 hits, L1 misses and all writebacks.
  - Counters saturate at all-ones and reset to 0; clear does not reset them.
- Disabled: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package l2_coh_pkg holds:
  - mesi_t (M/E/S/I)
  - cmd_t (all command encodings)
  - snp_resp_t (NOHIT/HIT/HITM)
  - bus_op_t
  - FSM state enum
- Sub-module l2_mesi_next: pure combinational next-state and snoop-result function of (state, cmd, bus_snoop_resp), instantiated once by the controller.

Test Plan:
- After reset, L1 read 0x0000_1040 with bus_snoop_resp=NOHIT → bus READ to 0x0000_1040, done_state=E.
- Same address, second read → no bus_valid; done_valid exactly 2 cycles after the handshake; state E.
- L1 write to a line in S → INVALIDATE, then done_state=M. Later L1 read 0x0000_2040 (same index 1, different tag) → WRITEBACK 0x0000_1040, then READ 0x0000_2040.
- Snoop read on a line in M → snp_result=HITM, WRITEBACK issued, line becomes S. Snoop RFO on a line in S → HIT, line becomes I.
- snp_valid and l1_valid asserted in the same cycle → snp_ready=1, l1_ready=0; L1 accepted after snoop completion. bus_ready held low 5 cycles → bus_valid/bus_op/bus_addr stable throughout.
- clear with lines in M/E/S → all lines I; a subsequent read misses. rst_n asserted during BUSOP → bus_valid=0 immediately, no done pulse.
